// File: rtl/pixel_stream_gen_if.sv
// Word-fetch handshake between the frame-buffer fetch logic (master) and the
// pixel generator (slave): packed palette indices plus a flag bit.
interface pixel_stream_gen_if #(
  parameter int WORD_WIDTH = 16
) ();
  logic                  word_valid;
  logic                  word_ready;
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_flag;

  modport master (output word_valid, word_data, word_flag, input word_ready);
  modport slave  (input word_valid, word_data, word_flag, output word_ready);
endinterface

// File: rtl/pixel_stream_gen.sv
// Pixel generator: two-word skid (shift + holding), palette lookup, registered RGB/syncs.
// Optional PIXEL_STREAM_GEN_UNDERFLOW_CNT_EN adds a saturating 16-bit underflow counter.
module pixel_stream_gen #(
  parameter int          BPP         = 2,
  parameter int          WORD_WIDTH  = 16,
  parameter int          COLOR_WIDTH = 8,
  parameter logic [23:0] BG_COLOR    = 24'h323232
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  pixel_stream_gen_if.slave        word_bus,
  input  logic                     bright,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic                     pal_we,
  input  logic [BPP-1:0]           pal_addr,
  input  logic [3*COLOR_WIDTH-1:0] pal_data,
  output logic [COLOR_WIDTH-1:0]   r,
  output logic [COLOR_WIDTH-1:0]   g,
  output logic [COLOR_WIDTH-1:0]   b,
  output logic                     hsync_o,
  output logic                     vsync_o,
  output logic                     bright_o,
  output logic                     underflow
`ifdef PIXEL_STREAM_GEN_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]              underflow_cnt
`endif
);

  localparam int PPW       = WORD_WIDTH / BPP;
  localparam int PCNT_W    = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int PAL_DEPTH = 1 << BPP;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PPW - 1);

  if (WORD_WIDTH % BPP != 0) begin : g_bad_width
    $error("pixel_stream_gen: WORD_WIDTH must be a multiple of BPP");
  end

  // 8-bit-per-channel constants are zero-extended or truncated to COLOR_WIDTH.
  function automatic logic [3*COLOR_WIDTH-1:0] to_rgb(input logic [23:0] c);
    logic [31:0] rr, gg, bb;
    rr = {24'd0, c[23:16]};
    gg = {24'd0, c[15:8]};
    bb = {24'd0, c[7:0]};
    return {rr[COLOR_WIDTH-1:0], gg[COLOR_WIDTH-1:0], bb[COLOR_WIDTH-1:0]};
  endfunction

  function automatic logic [23:0] pal_init(input int idx);
    case (idx)
      0:       return 24'h323232;
      1:       return 24'hFF0000;
      2:       return 24'h00FF00;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  localparam logic [3*COLOR_WIDTH-1:0] BG_RGB = to_rgb(BG_COLOR);

  logic [WORD_WIDTH-1:0]    sr_word_reg, sr_word_next;
  logic                     sr_flag_reg, sr_flag_next;
  logic                     sr_valid_reg, sr_valid_next;
  logic [PCNT_W-1:0]        pcnt_reg, pcnt_next;
  logic [WORD_WIDTH-1:0]    hr_word_reg, hr_word_next;
  logic                     hr_flag_reg, hr_flag_next;
  logic                     hr_valid_reg, hr_valid_next;
  logic [3*COLOR_WIDTH-1:0] palette_reg [PAL_DEPTH];
  logic [3*COLOR_WIDTH-1:0] rgb_reg, rgb_next;
  logic                     underflow_next;
  logic                     accept;
  logic [BPP-1:0]           pix_idx [PPW];

  for (genvar gi = 0; gi < PPW; gi++) begin : g_pix
    assign pix_idx[gi] = sr_word_reg[gi*BPP +: BPP];
  end

  assign word_bus.word_ready = !hr_valid_reg && !flush && !reset;
  assign accept = word_bus.word_valid && word_bus.word_ready;

  always_comb begin
    sr_word_next  = sr_word_reg;
    sr_flag_next  = sr_flag_reg;
    sr_valid_next = sr_valid_reg;
    pcnt_next     = pcnt_reg;
    hr_word_next  = hr_word_reg;
    hr_flag_next  = hr_flag_reg;
    hr_valid_next = hr_valid_reg;
    if (flush) begin
      sr_valid_next = 1'b0;
      hr_valid_next = 1'b0;
      pcnt_next     = '0;
    end else begin
      if (!sr_valid_reg && hr_valid_reg) begin
        sr_word_next  = hr_word_reg;
        sr_flag_next  = hr_flag_reg;
        sr_valid_next = 1'b1;
        pcnt_next     = '0;
        hr_valid_next = 1'b0;
      end else if (bright && sr_valid_reg) begin
        if (pcnt_reg == PCNT_LAST) begin
          pcnt_next = '0;
          if (hr_valid_reg) begin
            sr_word_next  = hr_word_reg;
            sr_flag_next  = hr_flag_reg;
            hr_valid_next = 1'b0;
          end else begin
            sr_valid_next = 1'b0;
          end
        end else begin
          pcnt_next = pcnt_reg + 1'b1;
        end
      end
      // Accept only happens with HR empty, so it never collides with the HR drain above.
      if (accept) begin
        hr_word_next  = word_bus.word_data;
        hr_flag_next  = word_bus.word_flag;
        hr_valid_next = 1'b1;
      end
    end
  end

  always_comb begin
    rgb_next       = BG_RGB;
    underflow_next = bright && !sr_valid_reg;
    if (bright && sr_valid_reg && !sr_flag_reg) begin
      rgb_next = palette_reg[pix_idx[pcnt_reg]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_word_reg  <= '0;
      sr_flag_reg  <= 1'b0;
      sr_valid_reg <= 1'b0;
      pcnt_reg     <= '0;
      hr_word_reg  <= '0;
      hr_flag_reg  <= 1'b0;
      hr_valid_reg <= 1'b0;
      rgb_reg      <= BG_RGB;
      hsync_o      <= 1'b1;
      vsync_o      <= 1'b1;
      bright_o     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      sr_word_reg  <= sr_word_next;
      sr_flag_reg  <= sr_flag_next;
      sr_valid_reg <= sr_valid_next;
      pcnt_reg     <= pcnt_next;
      hr_word_reg  <= hr_word_next;
      hr_flag_reg  <= hr_flag_next;
      hr_valid_reg <= hr_valid_next;
      rgb_reg      <= rgb_next;
      hsync_o      <= hsync;
      vsync_o      <= vsync;
      bright_o     <= bright;
      underflow    <= underflow_next;
    end
  end

  // Writes land at the clock edge, so a same-cycle lookup still sees the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        palette_reg[i] <= to_rgb(pal_init(i));
      end
    end else if (pal_we) begin
      palette_reg[pal_addr] <= pal_data;
    end
  end

  assign r = rgb_reg[3*COLOR_WIDTH-1 -: COLOR_WIDTH];
  assign g = rgb_reg[2*COLOR_WIDTH-1 -: COLOR_WIDTH];
  assign b = rgb_reg[COLOR_WIDTH-1:0];

`ifdef PIXEL_STREAM_GEN_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      uf_cnt_reg <= '0;
    end else if (underflow_next && uf_cnt_reg != 16'hFFFF) begin
      uf_cnt_reg <= uf_cnt_reg + 16'd1;
    end
  end

  assign underflow_cnt = uf_cnt_reg;
`endif

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Directed bench for pixel_stream_gen: word-queue model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_pixel_stream_gen;
  localparam int          WW  = 16;
  localparam int          PPW = 8;
  localparam logic [23:0] BG  = 24'h323232;
  localparam logic [23:0] T1 [4] = '{24'h323232, 24'hFF0000, 24'h00FF00, 24'hFFFFFF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, bright, hsync, vsync, pal_we;
  logic [1:0]  pal_addr;
  logic [23:0] pal_data;
  logic [7:0]  r, g, b;
  logic        hsync_o, vsync_o, bright_o, underflow;
`ifdef PIXEL_STREAM_GEN_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  pixel_stream_gen_if #(.WORD_WIDTH(WW)) bus ();

  pixel_stream_gen #(.BPP(2), .WORD_WIDTH(WW), .COLOR_WIDTH(8), .BG_COLOR(BG)) dut (
    .clk(clk), .reset(reset), .flush(flush), .word_bus(bus),
    .bright(bright), .hsync(hsync), .vsync(vsync),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .r(r), .g(g), .b(b),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .bright_o(bright_o), .underflow(underflow)
`ifdef PIXEL_STREAM_GEN_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  typedef struct packed {
    logic        flag;
    logic [15:0] data;
  } word_t;

  // Model: words queued in the block; the head is on screen once "showing" is set.
  word_t       q[$];
  bit          m_showing;
  int          m_pix;
  int          m_cnt;
  logic [23:0] m_pal [4];
  int          tests = 0;
  int          fails = 0;
  bit          last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_showing = 0;
    m_pix     = 0;
    m_cnt     = 0;
    for (int i = 0; i < 4; i++) m_pal[i] = T1[i];
  endtask

  // One clock: check ready, predict registered outputs, clock, compare, advance model.
  task automatic step();
    bit          hr_occ, e_ready, acc;
    logic [23:0] e_rgb;
    logic        e_hs, e_vs, e_bo, e_uf;
    logic [1:0]  idx;
    word_t       w;
    #1;
    hr_occ  = (q.size() == 2) || (q.size() == 1 && !m_showing);
    e_ready = !reset && !flush && !hr_occ;
    chk("word_ready", bus.word_ready, e_ready);
    acc = bus.word_valid && e_ready;
    if (reset) begin
      e_rgb = BG; e_hs = 1; e_vs = 1; e_bo = 0; e_uf = 0;
    end else begin
      e_hs = hsync; e_vs = vsync; e_bo = bright;
      e_uf = bright && !m_showing;
      e_rgb = BG;
      if (bright && m_showing) begin
        w   = q[0];
        idx = 2'(w.data >> (2 * m_pix));
        e_rgb = w.flag ? BG : m_pal[idx];
      end
    end
    if (reset) begin
      model_reset();
    end else begin
      if (flush) begin
        q.delete();
        m_showing = 0;
        m_pix     = 0;
        m_cnt     = 0;
      end else begin
        if (e_uf && m_cnt < 65535) m_cnt++;
        if (!m_showing && q.size() > 0) begin
          m_showing = 1;
          m_pix     = 0;
        end else if (bright && m_showing) begin
          m_pix++;
          if (m_pix == PPW) begin
            void'(q.pop_front());
            m_pix     = 0;
            m_showing = (q.size() > 0);
          end
        end
        if (acc) q.push_back(word_t'{flag: bus.word_flag, data: bus.word_data});
      end
      if (pal_we) m_pal[pal_addr] = pal_data;
    end
    @(posedge clk);
    #1;
    chk("rgb", {r, g, b}, e_rgb);
    chk("hsync_o", hsync_o, e_hs);
    chk("vsync_o", vsync_o, e_vs);
    chk("bright_o", bright_o, e_bo);
    chk("underflow", underflow, e_uf);
`ifdef PIXEL_STREAM_GEN_UNDERFLOW_CNT_EN
    chk("underflow_cnt", underflow_cnt, m_cnt);
`endif
    last_acc = acc;
    if (acc) $display("[TB] word %h flag %0d accepted at %0t", bus.word_data, bus.word_flag, $time);
  endtask

  task automatic send_word(input logic [15:0] d, input logic f);
    bus.word_valid = 1;
    bus.word_data  = d;
    bus.word_flag  = f;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_acc) break;
    end
    chk("send_accept", last_acc, 1);
    bus.word_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; flush = 0; bright = 0; hsync = 1; vsync = 1;
    pal_we = 0; pal_addr = 0; pal_data = 0;
    bus.word_valid = 0; bus.word_data = 0; bus.word_flag = 0;
    model_reset();
    @(posedge clk);
    #1;
    step();
    step();
    chk("rst_rgb", {r, g, b}, 24'h323232);
    chk("rst_hsync_o", hsync_o, 1);
    chk("rst_bright_o", bright_o, 0);
    chk("rst_underflow", underflow, 0);
    reset = 0;

    // E4E4: grey, red, green, white twice, then underflow
    send_word(16'hE4E4, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      bright = 1;
      step();
      chk("t1_pix", {r, g, b}, T1[i % 4]);
    end
    step();
    chk("t1_uf_rgb", {r, g, b}, BG);
    chk("t1_uf", underflow, 1);
    bright = 0;

    // Back-to-back 5555 / AAAA
    send_word(16'h5555, 0);
    send_word(16'hAAAA, 0);
    #1;
    chk("t2_ready_full", bus.word_ready, 0);
    for (int i = 0; i < 16; i++) begin
      bright = 1;
      step();
      chk("t2_pix", {r, g, b}, (i < 8) ? 24'hFF0000 : 24'h00FF00);
      chk("t2_no_uf", underflow, 0);
    end
    bright = 0;

    // Flagged word renders background, unflagged renders white
    send_word(16'hFFFF, 1);
    step();
    for (int i = 0; i < 8; i++) begin
      bright = 1;
      step();
      chk("t3_flag", {r, g, b}, 24'h323232);
    end
    bright = 0;
    send_word(16'hFFFF, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      bright = 1;
      step();
      chk("t3_white", {r, g, b}, 24'hFFFFFF);
    end
    bright = 0;

    // Palette write during pixel 0: pixel 0 old red, the rest blue
    send_word(16'h5555, 0);
    step();
    bright = 1; pal_we = 1; pal_addr = 2'd1; pal_data = 24'h0000FF;
    step();
    chk("t4_pix0", {r, g, b}, 24'hFF0000);
    pal_we = 0;
    for (int i = 1; i < 8; i++) begin
      step();
      chk("t4_blue", {r, g, b}, 24'h0000FF);
    end
    bright = 0;

    // Flush at pcnt=3 with HR full and a word on offer
    send_word(16'hE4E4, 0);
    step();
    send_word(16'h5555, 0);
    bright = 1;
    for (int i = 0; i < 3; i++) step();
    bright = 0; flush = 1;
    bus.word_valid = 1; bus.word_data = 16'h1234; bus.word_flag = 0;
    #1;
    chk("t5_flush_ready", bus.word_ready, 0);
    step();
    chk("t5_flush_noacc", last_acc, 0);
    flush = 0; bright = 1;
    step();
    chk("t5_acc_after", last_acc, 1);
    chk("t5_bg", {r, g, b}, BG);
    chk("t5_uf", underflow, 1);
    bus.word_valid = 0; bright = 0;
    step();

    // bright gap and sync pulses, then three underflows
    reset = 1;
    step();
    reset = 0;
    send_word(16'hE4E4, 0);
    step();
    bright = 1;
    step();
    chk("t6_pix0", {r, g, b}, 24'h323232);
    bright = 0; hsync = 0; vsync = 0;
    step();
    chk("t6_gap_rgb", {r, g, b}, BG);
    chk("t6_hs_low", hsync_o, 0);
    chk("t6_vs_low", vsync_o, 0);
    chk("t6_bo_low", bright_o, 0);
    bright = 1; hsync = 1; vsync = 1;
    step();
    chk("t6_pix1", {r, g, b}, 24'hFF0000);
    chk("t6_hs_high", hsync_o, 1);
    for (int i = 2; i < 8; i++) step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_uf", underflow, 1);
    end
`ifdef PIXEL_STREAM_GEN_UNDERFLOW_CNT_EN
    chk("t6_uf_cnt", underflow_cnt, 3);
`endif
    bright = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pixel_stream_gen.md
Name: pixel_stream_gen

Overview:
- Parametrised pixel generator for the VGA path.
- Takes packed palette-index words from the frame-buffer fetch logic over a valid/ready handshake and buffers them in a two-word skid (shift + holding register).
- Shifts out one pixel per bright cycle through a run-time-writable palette and drives registered RGB plus delayed sync/bright, so timing stays aligned at the DAC.
- Replaces the fixed 2-bit, combinational colour decode with width-generic, pipelined, underflow-aware behaviour.

Parameters:
- BPP, 2, bits per pixel (palette index width); WORD_WIDTH % BPP == 0, checked at elaboration.
- WORD_WIDTH, 16, memory word width.
- COLOR_WIDTH, 8, bits per colour channel.
- BG_COLOR, 24'h323232, {r,g,b} driven when blank, underflowing or flagged (requires COLOR_WIDTH=8; otherwise zero-extended/truncated per channel).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous buffer clear (driven at frame start)
- word_valid  in  1  fetch presents a word
- word_ready  out  1  block accepts the word this cycle
- word_data  in  WORD_WIDTH  packed pixel indices
- word_flag  in  1  word is a flag/control address; all its pixels render BG_COLOR
- bright  in  1  visible-area pixel strobe
- hsync, vsync  in  1  syncs from the timing generator
- pal_we  in  1  palette write strobe
- pal_addr  in  BPP  palette entry
- pal_data  in  3*COLOR_WIDTH  {r,g,b}
- r, g, b  out  COLOR_WIDTH  registered colour
- hsync_o, vsync_o, bright_o  out  1  syncs/bright delayed to match RGB
- underflow  out  1  one-cycle pulse: bright with no pixel available

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - r/g/b = BG_COLOR; hsync_o = vsync_o = 1; bright_o = 0; underflow = 0.
  - Shift and holding registers invalid; pixel counter = 0.
  - Palette resets to: 0 = 50,50,50; 1 = 255,0,0; 2 = 0,255,0; 3 = 255,255,255; all indices >= 4 = 255,255,255.
- PPW = WORD_WIDTH/BPP. Pixel k = word_data[k*BPP +: BPP]; pixel 0 (LSBs) is displayed first.
- Storage: SR (shift word + flag) with sr_valid and pcnt (0..PPW-1); HR (holding word + flag) with hr_valid.
- Handshake: word_ready = !hr_valid && !flush && !reset (combinational). A transfer occurs when word_valid && word_ready; HR is loaded and hr_valid set.
- Refill: if !sr_valid && hr_valid, SR <= HR, hr_valid clears, pcnt <= 0 (one cycle, independent of bright). If the same cycle also accepts a new word, the new word lands in HR with no loss.
- Pixel cycle (bright=1, sr_valid=1):
  - Colour = BG_COLOR if the SR flag is set, else palette[SR pixel pcnt].
  - pcnt increments. At pcnt == PPW-1: pcnt <= 0; if hr_valid, SR <= HR and hr_valid clears; else sr_valid <= 0.
- bright=1, sr_valid=0: colour = BG_COLOR, underflow pulses, no pixel consumed. A refill in the same cycle is still performed.
- bright=0: colour = BG_COLOR; SR, pcnt and HR hold (apart from refill).
- Latency: r/g/b, hsync_o, vsync_o and bright_o all register inputs from cycle N and appear at cycle N+1. Underflow is registered identically.
- Palette: write at cycle N affects pixels sampled from cycle N+1. A same-cycle read of the written index uses the old value.
- flush: priority over every transfer, refill and consume. It clears sr_valid, hr_valid and pcnt; a word offered that cycle is not accepted. Output pipeline registers still update normally; the palette is untouched.
- reset mid-word: everything returns to reset values, including the palette.

Optional Feature:
- Macro: PIXEL_STREAM_GEN_UNDERFLOW_CNT_EN.
- Defined: adds output underflow_cnt [15:0], saturating at 16'hFFFF. It increments on each underflow pulse and clears on reset or flush.
- Undefined: port and counter absent; the underflow pulse remains.

Test Plan:
- Reset, then word 16'hE4E4 (flag=0), then 8 bright cycles -> RGB sequence grey, red, green, white, grey, red, green, white at 1-cycle latency; sr_valid drops; 9th bright cycle -> BG_COLOR and underflow=1.
- Back-to-back words 16'h5555 then 16'hAAAA with word_valid held -> second word accepted while the first is displaying; 16 consecutive bright cycles -> 8 red then 8 green, no underflow; word_ready=0 while HR is full.
- Word 16'hFFFF with word_flag=1, 8 bright cycles -> all 50,50,50; a following 16'hFFFF with flag=0 -> 8 white.
- Write palette entry 1 = 24'h0000FF at the cycle between pixels 0 and 1 of word 16'h5555 -> pixel 0 red, pixels 1-7 blue.
- Flush asserted at pcnt=3 with HR full and word_valid=1 -> word_ready=0 that cycle; next bright cycle -> BG_COLOR with underflow=1; the offered word is accepted the following cycle.
- bright toggled 1,0,1 mid-word, hsync/vsync pulsed -> pixel index does not advance during bright=0; hsync_o/vsync_o/bright_o are exactly 1-cycle-delayed copies. With the macro defined, 3 underflow cycles -> underflow_cnt=3.
